mem_arbiter: RTL and testbench

Two-requester arbiter and sequencer for the single shared memory port. It multiplexes the instruction fetch stage (fetches at the current pc) and the MEM stage (loads/stores) onto one req/ack bus. It also runs a per-transfer timeout and discards fetches killed by a jump or exception redirect. It raises a stall request whenever either requester waits, so the pipeline holds pc and downstream stages.

---
 rtl/mem_arbiter_if.sv | 48 ++++
 rtl/mem_arbiter.sv | 174 +++++++++++++++++
 tb/tb_mem_arbiter.sv | 334 +++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_arbiter_if.sv
// Signal bundle between the pipeline requesters, the arbiter and the shared
// memory port. The arbiter uses the master modport and the environment (pipeline
// stages plus the memory slave) uses the slave modport.
interface mem_arbiter_if;
  // Instruction fetch requester
  logic        if_req;
  logic [31:0] if_addr;
  logic [31:0] if_rdata;
  logic        if_ack;
  logic        flush;
  // MEM stage requester
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_sel;
  logic [31:0] mem_rdata;
  logic        mem_ack;
  // Shared memory port
  logic        bus_req;
  logic        bus_we;
  logic [31:0] bus_addr;
  logic [31:0] bus_wdata;
  logic [3:0]  bus_sel;
  logic [31:0] bus_rdata;
  logic        bus_ack;
  logic        bus_err;
  // Pipeline hold
  logic        stall_req;

  modport master (
    input  if_req, if_addr, flush,
    input  mem_req, mem_we, mem_addr, mem_wdata, mem_sel,
    input  bus_rdata, bus_ack,
    output if_rdata, if_ack, mem_rdata, mem_ack,
    output bus_req, bus_we, bus_addr, bus_wdata, bus_sel, bus_err,
    output stall_req
  );

  modport slave (
    output if_req, if_addr, flush,
    output mem_req, mem_we, mem_addr, mem_wdata, mem_sel,
    output bus_rdata, bus_ack,
    input  if_rdata, if_ack, mem_rdata, mem_ack,
    input  bus_req, bus_we, bus_addr, bus_wdata, bus_sel, bus_err,
    input  stall_req
  );
endinterface

// File: rtl/mem_arbiter.sv
// Two-requester arbiter/sequencer for the single shared memory port.
// Fetch and MEM-stage requests are serialised onto one req/ack bus with a
// per-transfer timeout; fetches killed by flush are drained silently.
module mem_arbiter #(
  parameter int TIMEOUT = 15
) (
  input logic           clk,
  input logic           rst,
  mem_arbiter_if.master arb
);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    IF_XFER  = 2'd1,
    MEM_XFER = 2'd2,
    IF_DROP  = 2'd3
  } state_t;

  typedef enum logic {
    GRANT_IF  = 1'b0,
    GRANT_MEM = 1'b1
  } grant_t;

  localparam logic [7:0] TO_LAST = 8'(TIMEOUT - 1);

  state_t      state_q;
  grant_t      last_grant_q;
  logic [7:0]  cnt_q;
  logic [7:0]  cnt_d;
  logic        bus_req_q;
  logic        bus_we_q;
  logic [31:0] bus_addr_q;
  logic [31:0] bus_wdata_q;
  logic [3:0]  bus_sel_q;
  logic        bus_err_q;
  logic        if_ack_q;
  logic [31:0] if_rdata_q;
  logic        mem_ack_q;
  logic [31:0] mem_rdata_q;

  logic        if_elig;
  logic        mem_elig;
  logic        pick_mem;
  logic        timeout_hit;

  // A requester still high during its own ack pulse is not re-granted.
  assign if_elig     = arb.if_req & ~if_ack_q & ~arb.flush;
  assign mem_elig    = arb.mem_req & ~mem_ack_q;
  // MEM has priority unless it also won last time and a fetch is waiting.
  assign pick_mem    = mem_elig & (~if_elig | (last_grant_q == GRANT_IF));
  assign cnt_d       = cnt_q + 8'd1;
  assign timeout_hit = (cnt_q == TO_LAST);

  // Arbitration, transfer sequencing and timeout with registered outputs.
  // NOTE: the reset term is in the sensitivity list so that reset takes effect
  // immediately, independent of the clock.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      last_grant_q <= GRANT_IF;
      cnt_q        <= '0;
      bus_req_q    <= 1'b0;
      bus_we_q     <= 1'b0;
      bus_addr_q   <= '0;
      bus_wdata_q  <= '0;
      bus_sel_q    <= '0;
      bus_err_q    <= 1'b0;
      if_ack_q     <= 1'b0;
      if_rdata_q   <= '0;
      mem_ack_q    <= 1'b0;
      mem_rdata_q  <= '0;
    end else begin
      // NOTE: non-blocking assignments throughout; the pulse defaults below are
      // overridden later in the same block, and the last assignment wins.
      if_ack_q  <= 1'b0;
      mem_ack_q <= 1'b0;
      bus_err_q <= 1'b0;

      unique case (state_q)
        IDLE: begin
          if (pick_mem) begin
            bus_req_q    <= 1'b1;
            bus_we_q     <= arb.mem_we;
            bus_addr_q   <= arb.mem_addr;
            bus_wdata_q  <= arb.mem_wdata;
            bus_sel_q    <= arb.mem_sel;
            cnt_q        <= '0;
            last_grant_q <= GRANT_MEM;
            state_q      <= MEM_XFER;
          end else if (if_elig) begin
            bus_req_q    <= 1'b1;
            bus_we_q     <= 1'b0;
            bus_addr_q   <= arb.if_addr;
            bus_wdata_q  <= '0;
            bus_sel_q    <= 4'hF;
            cnt_q        <= '0;
            last_grant_q <= GRANT_IF;
            state_q      <= IF_XFER;
          end
        end

        IF_XFER: begin
          if (arb.bus_ack) begin
            bus_req_q <= 1'b0;
            state_q   <= IDLE;
            if (!arb.flush) begin
              if_ack_q   <= 1'b1;
              if_rdata_q <= arb.bus_rdata;
            end
          end else if (timeout_hit) begin
            bus_err_q <= 1'b1;
            bus_req_q <= 1'b0;
            state_q   <= IDLE;
            if (!arb.flush) begin
              if_ack_q   <= 1'b1;
              if_rdata_q <= '0;
            end
          end else begin
            cnt_q <= cnt_d;
            // Keep bus_req high so the slave can finish the killed fetch.
            if (arb.flush) state_q <= IF_DROP;
          end
        end

        MEM_XFER: begin
          if (arb.bus_ack) begin
            bus_req_q   <= 1'b0;
            state_q     <= IDLE;
            mem_ack_q   <= 1'b1;
            mem_rdata_q <= arb.bus_rdata;
          end else if (timeout_hit) begin
            bus_err_q   <= 1'b1;
            bus_req_q   <= 1'b0;
            state_q     <= IDLE;
            mem_ack_q   <= 1'b1;
            mem_rdata_q <= '0;
          end else begin
            cnt_q <= cnt_d;
          end
        end

        IF_DROP: begin
          if (arb.bus_ack) begin
            bus_req_q <= 1'b0;
            state_q   <= IDLE;
          end else if (timeout_hit) begin
            bus_err_q <= 1'b1;
            bus_req_q <= 1'b0;
            state_q   <= IDLE;
          end else begin
            cnt_q <= cnt_d;
          end
        end

        default: state_q <= IDLE;
      endcase
    end
  end

  // Registered outputs onto the bundle; stall_req is the only combinational one.
  assign arb.bus_req   = bus_req_q;
  assign arb.bus_we    = bus_we_q;
  assign arb.bus_addr  = bus_addr_q;
  assign arb.bus_wdata = bus_wdata_q;
  assign arb.bus_sel   = bus_sel_q;
  assign arb.bus_err   = bus_err_q;
  assign arb.if_ack    = if_ack_q;
  assign arb.if_rdata  = if_rdata_q;
  assign arb.mem_ack   = mem_ack_q;
  assign arb.mem_rdata = mem_rdata_q;
  assign arb.stall_req = (arb.if_req & ~if_ack_q & ~arb.flush) |
                         (arb.mem_req & ~mem_ack_q);

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter (TIMEOUT = 4): directed scenarios plus
// randomized rounds checked against a transaction-level arbitration model.
module tb_mem_arbiter;

  logic clk = 1'b0;
  logic rst;

  mem_arbiter_if bus_if ();

  mem_arbiter #(.TIMEOUT(4)) dut (
    .clk (clk),
    .rst (rst),
    .arb (bus_if)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  // Model state: rdata each port should be holding, and who was granted last.
  logic [31:0] exp_if_rdata  = '0;
  logic [31:0] exp_mem_rdata = '0;
  logic        exp_last_mem  = 1'b0;

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus_if.if_req    = 1'b0;
    bus_if.if_addr   = '0;
    bus_if.flush     = 1'b0;
    bus_if.mem_req   = 1'b0;
    bus_if.mem_we    = 1'b0;
    bus_if.mem_addr  = '0;
    bus_if.mem_wdata = '0;
    bus_if.mem_sel   = '0;
    bus_if.bus_rdata = '0;
    bus_if.bus_ack   = 1'b0;
  endtask

  function automatic logic [137:0] outs();
    return {bus_if.bus_req, bus_if.bus_we, bus_if.bus_addr, bus_if.bus_wdata,
            bus_if.bus_sel, bus_if.bus_err, bus_if.if_ack, bus_if.if_rdata,
            bus_if.mem_ack, bus_if.mem_rdata, bus_if.stall_req};
  endfunction

  task automatic test_reset();
    rst = 1'b1;
    idle_inputs();
    cycle();
    n_checks++; if (outs() !== '0) $display("FAIL reset.outs got %h want 0", outs()); else n_pass++;
    cycle();
    n_checks++; if (bus_if.stall_req !== 1'b0) $display("FAIL reset.stall got %b want 0", bus_if.stall_req); else n_pass++;
    rst = 1'b0;
    exp_if_rdata = '0; exp_mem_rdata = '0; exp_last_mem = 1'b0;
    cycle();
    n_checks++; if (outs() !== '0) $display("FAIL reset.idle got %h want 0", outs()); else n_pass++;
  endtask

  task automatic test_lone_fetch();
    // cycle 0
    bus_if.if_req = 1'b1; bus_if.if_addr = 32'h100;
    #1;
    n_checks++; if (bus_if.stall_req !== 1'b1) $display("FAIL lone.stall_c0 got %b want 1", bus_if.stall_req); else n_pass++;
    cycle();
    // cycle 1: granted, slave acks immediately
    n_checks++; if ({bus_if.bus_req, bus_if.bus_we, bus_if.bus_sel, bus_if.bus_addr} !== {1'b1, 1'b0, 4'hF, 32'h100})
      $display("FAIL lone.grant got %b/%b/%h/%h want 1/0/f/100", bus_if.bus_req, bus_if.bus_we, bus_if.bus_sel, bus_if.bus_addr); else n_pass++;
    bus_if.bus_ack = 1'b1; bus_if.bus_rdata = 32'h2402000A;
    #1;
    n_checks++; if (bus_if.stall_req !== 1'b1) $display("FAIL lone.stall_c1 got %b want 1", bus_if.stall_req); else n_pass++;
    cycle();
    // cycle 2: ack pulse, request still held
    bus_if.bus_ack = 1'b0;
    exp_if_rdata = 32'h2402000A;
    exp_last_mem = 1'b0;
    n_checks++; if ({bus_if.if_ack, bus_if.if_rdata, bus_if.bus_req} !== {1'b1, exp_if_rdata, 1'b0})
      $display("FAIL lone.ack got %b/%h/%b want 1/%h/0", bus_if.if_ack, bus_if.if_rdata, bus_if.bus_req, exp_if_rdata); else n_pass++;
    #1;
    n_checks++; if (bus_if.stall_req !== 1'b0) $display("FAIL lone.stall_c2 got %b want 0", bus_if.stall_req); else n_pass++;
    cycle();
    // cycle 3: no re-grant of the acked request, rdata holds
    bus_if.if_req = 1'b0;
    n_checks++; if ({bus_if.bus_req, bus_if.if_ack, bus_if.if_rdata} !== {1'b0, 1'b0, exp_if_rdata})
      $display("FAIL lone.after got %b/%b/%h want 0/0/%h", bus_if.bus_req, bus_if.if_ack, bus_if.if_rdata, exp_if_rdata); else n_pass++;
  endtask

  task automatic test_contention();
    // c0: store and fetch rise together
    bus_if.if_req = 1'b1; bus_if.if_addr = 32'h104;
    bus_if.mem_req = 1'b1; bus_if.mem_we = 1'b1; bus_if.mem_addr = 32'h40;
    bus_if.mem_wdata = 32'hDEADBEEF; bus_if.mem_sel = 4'b0011;
    cycle();
    // c1: MEM first
    n_checks++; if ({bus_if.bus_req, bus_if.bus_we, bus_if.bus_sel, bus_if.bus_addr, bus_if.bus_wdata} !== {1'b1, 1'b1, 4'b0011, 32'h40, 32'hDEADBEEF})
      $display("FAIL cont.mem_first got %b/%b/%h/%h/%h want 1/1/3/40/deadbeef", bus_if.bus_req, bus_if.bus_we, bus_if.bus_sel, bus_if.bus_addr, bus_if.bus_wdata); else n_pass++;
    bus_if.bus_ack = 1'b1; bus_if.bus_rdata = 32'h11111111;
    cycle();
    // c2: mem_ack, fetch still pending
    bus_if.bus_ack = 1'b0;
    exp_mem_rdata = 32'h11111111;
    n_checks++; if ({bus_if.mem_ack, bus_if.if_ack, bus_if.bus_req, bus_if.mem_rdata} !== {1'b1, 1'b0, 1'b0, exp_mem_rdata})
      $display("FAIL cont.mem_ack got %b/%b/%b/%h want 1/0/0/%h", bus_if.mem_ack, bus_if.if_ack, bus_if.bus_req, bus_if.mem_rdata, exp_mem_rdata); else n_pass++;
    cycle();
    // c3: IF granted right after mem_ack
    bus_if.mem_req = 1'b0;
    n_checks++; if ({bus_if.bus_req, bus_if.bus_we, bus_if.bus_sel, bus_if.bus_addr, bus_if.bus_wdata} !== {1'b1, 1'b0, 4'hF, 32'h104, 32'h0})
      $display("FAIL cont.if_next got %b/%b/%h/%h/%h want 1/0/f/104/0", bus_if.bus_req, bus_if.bus_we, bus_if.bus_sel, bus_if.bus_addr, bus_if.bus_wdata); else n_pass++;
    bus_if.bus_ack = 1'b1; bus_if.bus_rdata = 32'h00000093;
    cycle();
    // c4: if_ack; a load is raised in the same cycle
    bus_if.bus_ack = 1'b0;
    exp_if_rdata = 32'h00000093;
    n_checks++; if ({bus_if.if_ack, bus_if.if_rdata} !== {1'b1, exp_if_rdata})
      $display("FAIL cont.if_ack got %b/%h want 1/%h", bus_if.if_ack, bus_if.if_rdata, exp_if_rdata); else n_pass++;
    bus_if.mem_req = 1'b1; bus_if.mem_we = 1'b0; bus_if.mem_addr = 32'h44; bus_if.mem_sel = 4'b1100;
    cycle();
    // c5: load granted (fetch excluded during its ack)
    bus_if.if_req = 1'b0;
    n_checks++; if ({bus_if.bus_req, bus_if.bus_we, bus_if.bus_sel, bus_if.bus_addr} !== {1'b1, 1'b0, 4'b1100, 32'h44})
      $display("FAIL cont.load got %b/%b/%h/%h want 1/0/c/44", bus_if.bus_req, bus_if.bus_we, bus_if.bus_sel, bus_if.bus_addr); else n_pass++;
    bus_if.bus_ack = 1'b1; bus_if.bus_rdata = 32'h5555AAAA;
    cycle();
    // c6: load ack
    bus_if.bus_ack = 1'b0;
    exp_mem_rdata = 32'h5555AAAA;
    n_checks++; if ({bus_if.mem_ack, bus_if.mem_rdata} !== {1'b1, exp_mem_rdata})
      $display("FAIL cont.load_ack got %b/%h want 1/%h", bus_if.mem_ack, bus_if.mem_rdata, exp_mem_rdata); else n_pass++;
    cycle();
    // c7: new store and a fetch both eligible; MEM won last, so IF wins
    bus_if.mem_req = 1'b1; bus_if.mem_we = 1'b1; bus_if.mem_addr = 32'h48;
    bus_if.mem_wdata = 32'h12345678; bus_if.mem_sel = 4'hF;
    bus_if.if_req = 1'b1; bus_if.if_addr = 32'h108;
    cycle();
    // c8
    n_checks++; if ({bus_if.bus_req, bus_if.bus_we, bus_if.bus_addr} !== {1'b1, 1'b0, 32'h108})
      $display("FAIL cont.alternate got %b/%b/%h want 1/0/108", bus_if.bus_req, bus_if.bus_we, bus_if.bus_addr); else n_pass++;
    bus_if.bus_ack = 1'b1; bus_if.bus_rdata = 32'h00000013;
    cycle();
    // c9
    bus_if.bus_ack = 1'b0;
    exp_if_rdata = 32'h00000013;
    n_checks++; if ({bus_if.if_ack, bus_if.mem_ack, bus_if.if_rdata} !== {1'b1, 1'b0, exp_if_rdata})
      $display("FAIL cont.alt_ack got %b/%b/%h want 1/0/%h", bus_if.if_ack, bus_if.mem_ack, bus_if.if_rdata, exp_if_rdata); else n_pass++;
    cycle();
    // c10: the waiting store follows
    bus_if.if_req = 1'b0;
    n_checks++; if ({bus_if.bus_req, bus_if.bus_we, bus_if.bus_addr, bus_if.bus_wdata} !== {1'b1, 1'b1, 32'h48, 32'h12345678})
      $display("FAIL cont.store2 got %b/%b/%h/%h want 1/1/48/12345678", bus_if.bus_req, bus_if.bus_we, bus_if.bus_addr, bus_if.bus_wdata); else n_pass++;
    bus_if.bus_ack = 1'b1; bus_if.bus_rdata = 32'hA5A5A5A5;
    cycle();
    bus_if.bus_ack = 1'b0;
    exp_mem_rdata = 32'hA5A5A5A5;
    exp_last_mem  = 1'b1;
    n_checks++; if ({bus_if.mem_ack, bus_if.mem_rdata} !== {1'b1, exp_mem_rdata})
      $display("FAIL cont.store2_ack got %b/%h want 1/%h", bus_if.mem_ack, bus_if.mem_rdata, exp_mem_rdata); else n_pass++;
    cycle();
    bus_if.mem_req = 1'b0;
    n_checks++; if (bus_if.bus_req !== 1'b0) $display("FAIL cont.idle got %b want 0", bus_if.bus_req); else n_pass++;
  endtask

  task automatic test_flush();
    bus_if.if_req = 1'b1; bus_if.if_addr = 32'h200;
    cycle();
    // c1
    n_checks++; if ({bus_if.bus_req, bus_if.bus_addr} !== {1'b1, 32'h200})
      $display("FAIL flush.grant got %b/%h want 1/200", bus_if.bus_req, bus_if.bus_addr); else n_pass++;
    cycle();
    // c2: flush pulse
    bus_if.flush = 1'b1;
    #1;
    n_checks++; if (bus_if.stall_req !== 1'b0) $display("FAIL flush.stall got %b want 0", bus_if.stall_req); else n_pass++;
    cycle();
    // c3: redirected fetch pending, old transfer still on the bus
    bus_if.flush = 1'b0; bus_if.if_addr = 32'h300;
    n_checks++; if ({bus_if.bus_req, bus_if.bus_addr, bus_if.if_ack} !== {1'b1, 32'h200, 1'b0})
      $display("FAIL flush.drain_c3 got %b/%h/%b want 1/200/0", bus_if.bus_req, bus_if.bus_addr, bus_if.if_ack); else n_pass++;
    cycle();
    // c4: slave finally acks the killed fetch
    n_checks++; if ({bus_if.bus_req, bus_if.if_ack, bus_if.bus_err} !== 3'b100)
      $display("FAIL flush.drain_c4 got %b/%b/%b want 1/0/0", bus_if.bus_req, bus_if.if_ack, bus_if.bus_err); else n_pass++;
    bus_if.bus_ack = 1'b1; bus_if.bus_rdata = 32'hBAD0BAD0;
    cycle();
    // c5: back in IDLE, data discarded
    bus_if.bus_ack = 1'b0;
    n_checks++; if ({bus_if.bus_req, bus_if.if_ack, bus_if.bus_err, bus_if.if_rdata} !== {3'b000, exp_if_rdata})
      $display("FAIL flush.discard got %b/%b/%b/%h want 0/0/0/%h", bus_if.bus_req, bus_if.if_ack, bus_if.bus_err, bus_if.if_rdata, exp_if_rdata); else n_pass++;
    cycle();
    // c6: new fetch granted
    n_checks++; if ({bus_if.bus_req, bus_if.bus_addr} !== {1'b1, 32'h300})
      $display("FAIL flush.refetch got %b/%h want 1/300", bus_if.bus_req, bus_if.bus_addr); else n_pass++;
    bus_if.bus_ack = 1'b1; bus_if.bus_rdata = 32'h00500093;
    cycle();
    bus_if.bus_ack = 1'b0;
    exp_if_rdata = 32'h00500093;
    exp_last_mem = 1'b0;
    n_checks++; if ({bus_if.if_ack, bus_if.if_rdata} !== {1'b1, exp_if_rdata})
      $display("FAIL flush.refetch_ack got %b/%h want 1/%h", bus_if.if_ack, bus_if.if_rdata, exp_if_rdata); else n_pass++;
    cycle();
    bus_if.if_req = 1'b0;
  endtask

  // Load to addr; ack_cycle = 0 means the slave never answers.
  task automatic test_timeout(input logic [31:0] addr, input int ack_cycle, input logic [31:0] rdata);
    bus_if.mem_req = 1'b1; bus_if.mem_we = 1'b0; bus_if.mem_addr = addr; bus_if.mem_sel = 4'hF;
    cycle();
    for (int c = 1; c <= 4; c++) begin
      n_checks++; if ({bus_if.bus_req, bus_if.bus_addr, bus_if.bus_err, bus_if.mem_ack} !== {1'b1, addr, 2'b00})
        $display("FAIL timeout.wait_c%0d got %b/%h/%b/%b want 1/%h/0/0", c, bus_if.bus_req, bus_if.bus_addr, bus_if.bus_err, bus_if.mem_ack, addr); else n_pass++;
      if (c == ack_cycle) begin
        bus_if.bus_ack = 1'b1; bus_if.bus_rdata = rdata;
      end
      cycle();
      bus_if.bus_ack = 1'b0;
    end
    // c5: either an abort or a normal completion
    exp_mem_rdata = (ack_cycle == 0) ? 32'h0 : rdata;
    exp_last_mem  = 1'b1;
    n_checks++; if ({bus_if.mem_ack, bus_if.bus_err, bus_if.bus_req, bus_if.mem_rdata} !== {1'b1, (ack_cycle == 0), 1'b0, exp_mem_rdata})
      $display("FAIL timeout.end got %b/%b/%b/%h want 1/%b/0/%h", bus_if.mem_ack, bus_if.bus_err, bus_if.bus_req, bus_if.mem_rdata, (ack_cycle == 0), exp_mem_rdata); else n_pass++;
    cycle();
    bus_if.mem_req = 1'b0;
    n_checks++; if ({bus_if.bus_req, bus_if.bus_err, bus_if.mem_ack} !== 3'b000)
      $display("FAIL timeout.idle got %b/%b/%b want 0/0/0", bus_if.bus_req, bus_if.bus_err, bus_if.mem_ack); else n_pass++;
  endtask

  task automatic test_reset_mid();
    bus_if.mem_req = 1'b1; bus_if.mem_we = 1'b1; bus_if.mem_addr = 32'h90;
    bus_if.mem_wdata = 32'h77; bus_if.mem_sel = 4'hF;
    cycle();
    n_checks++; if ({bus_if.bus_req, bus_if.bus_addr} !== {1'b1, 32'h90})
      $display("FAIL rstmid.grant got %b/%h want 1/90", bus_if.bus_req, bus_if.bus_addr); else n_pass++;
    #3;
    rst = 1'b1;
    idle_inputs();
    #1;
    n_checks++; if (outs() !== '0) $display("FAIL rstmid.async got %h want 0", outs()); else n_pass++;
    cycle();
    n_checks++; if (outs() !== '0) $display("FAIL rstmid.held got %h want 0", outs()); else n_pass++;
    rst = 1'b0;
    exp_if_rdata = '0; exp_mem_rdata = '0; exp_last_mem = 1'b0;
    test_lone_fetch();
  endtask

  // Randomized rounds: each round one or both requesters ask; the model
  // predicts grant order from the priority rule and each ack's data.
  task automatic test_random();
    logic [31:0] i_addr, m_addr, m_wdata, rd;
    logic        m_we, want_if, want_mem, w;
    logic [3:0]  m_sel;
    logic [31:0] e_addr, e_wdata;
    logic        e_we;
    logic [3:0]  e_sel;
    logic        order [2];
    int          n, lat;
    for (int r = 0; r < 40; r++) begin
      want_if  = 1'($urandom_range(0, 1));
      want_mem = 1'($urandom_range(0, 1));
      if (!want_if && !want_mem) want_if = 1'b1;
      i_addr  = $urandom() & 32'hFFFF_FFFC;
      m_addr  = $urandom();
      m_wdata = $urandom();
      m_we    = 1'($urandom_range(0, 1));
      m_sel   = 4'($urandom_range(1, 15));
      if (want_if && want_mem) begin
        order[0] = exp_last_mem ? 1'b0 : 1'b1;
        order[1] = ~order[0];
        n = 2;
      end else begin
        order[0] = want_mem;
        order[1] = 1'b0;
        n = 1;
      end
      bus_if.if_req  = want_if;  bus_if.if_addr   = i_addr;
      bus_if.mem_req = want_mem; bus_if.mem_addr  = m_addr;
      bus_if.mem_we  = m_we;     bus_if.mem_wdata = m_wdata; bus_if.mem_sel = m_sel;
      cycle();
      for (int k = 0; k < n; k++) begin
        w       = order[k];
        e_addr  = w ? m_addr  : i_addr;
        e_wdata = w ? m_wdata : 32'h0;
        e_we    = w ? m_we    : 1'b0;
        e_sel   = w ? m_sel   : 4'hF;
        n_checks++; if ({bus_if.bus_req, bus_if.bus_we, bus_if.bus_sel, bus_if.bus_addr, bus_if.bus_wdata} !== {1'b1, e_we, e_sel, e_addr, e_wdata})
          $display("FAIL rand.grant r%0d k%0d got %b/%b/%h/%h/%h want 1/%b/%h/%h/%h", r, k, bus_if.bus_req, bus_if.bus_we, bus_if.bus_sel, bus_if.bus_addr, bus_if.bus_wdata, e_we, e_sel, e_addr, e_wdata); else n_pass++;
        lat = $urandom_range(0, 3);
        for (int c = 0; c < lat; c++) begin
          cycle();
          n_checks++; if ({bus_if.bus_req, bus_if.if_ack, bus_if.mem_ack, bus_if.bus_err, bus_if.bus_addr} !== {4'b1000, e_addr})
            $display("FAIL rand.wait r%0d k%0d got %b%b%b%b/%h want 1000/%h", r, k, bus_if.bus_req, bus_if.if_ack, bus_if.mem_ack, bus_if.bus_err, bus_if.bus_addr, e_addr); else n_pass++;
        end
        rd = $urandom();
        bus_if.bus_ack = 1'b1; bus_if.bus_rdata = rd;
        cycle();
        bus_if.bus_ack = 1'b0;
        if (w) exp_mem_rdata = rd; else exp_if_rdata = rd;
        exp_last_mem = w;
        n_checks++; if ({bus_if.if_ack, bus_if.mem_ack, bus_if.bus_req, bus_if.bus_err} !== {~w, w, 2'b00})
          $display("FAIL rand.ack r%0d k%0d got %b%b%b%b want %b%b00", r, k, bus_if.if_ack, bus_if.mem_ack, bus_if.bus_req, bus_if.bus_err, ~w, w); else n_pass++;
        n_checks++; if ({bus_if.if_rdata, bus_if.mem_rdata} !== {exp_if_rdata, exp_mem_rdata})
          $display("FAIL rand.rdata r%0d k%0d got %h/%h want %h/%h", r, k, bus_if.if_rdata, bus_if.mem_rdata, exp_if_rdata, exp_mem_rdata); else n_pass++;
        n_checks++; if (bus_if.stall_req !== (k < n - 1))
          $display("FAIL rand.stall r%0d k%0d got %b want %b", r, k, bus_if.stall_req, (k < n - 1)); else n_pass++;
        cycle();
        if (w) bus_if.mem_req = 1'b0; else bus_if.if_req = 1'b0;
      end
      n_checks++; if (bus_if.bus_req !== 1'b0)
        $display("FAIL rand.no_regrant r%0d got %b want 0", r, bus_if.bus_req); else n_pass++;
    end
  endtask

  initial begin
    test_reset();
    test_lone_fetch();
    test_contention();
    test_flush();
    test_timeout(32'h80, 0, 32'h0);
    test_timeout(32'h84, 4, 32'hCAFEF00D);
    test_reset_mid();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got timeout want completion");
    $fatal(1, "bench did not complete");
  end

endmodule
